jpeg_idct_pass_arb: RTL and testbench

//  Shares one 1-D 8-point IDCT engine between two requesters: the row pass
//  (dequantised coefficients) and the column pass (transpose-buffer output).

---
 rtl/jpeg_idct_pass_arb.sv | 181 ++++++++++++++++++
 tb/tb_jpeg_idct_pass_arb.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/jpeg_idct_pass_arb.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : jpeg_idct_pass_arb                                            |
// | Purpose  : Shares one 1-D 8-point IDCT engine between the row pass       |
// |            (dequantised coefficients) and the column pass (transpose     |
// |            buffer output). Grants whole bursts of BURST_LEN beats, never |
// |            interleaves bursts, and tags each beat with its pass.          |
// | Ports    : clk_i, rst_i          clock, synchronous active-high reset     |
// |            img_start_i           synchronous flush at start of image      |
// |            row_valid_i/data/idx  row-pass beat in, row_accept_o back      |
// |            col_valid_i/data/idx  column-pass beat in, col_accept_o back   |
// |            outport_*             muxed beat to the IDCT engine            |
// |            outport_ready_i       IDCT engine can take a beat              |
// |            idle_o                no grant held and no request pending     |
// |            err_o                 sticky beat-index mismatch flag          |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module jpeg_idct_pass_arb #(
  parameter int DATA_W    = 32,
  parameter int BURST_LEN = 8,
  parameter int PRIO_COL  = 0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              img_start_i,
  input  logic              row_valid_i,
  input  logic [DATA_W-1:0] row_data0_i,
  input  logic [DATA_W-1:0] row_data1_i,
  input  logic [DATA_W-1:0] row_data2_i,
  input  logic [DATA_W-1:0] row_data3_i,
  input  logic [2:0]        row_idx_i,
  output logic              row_accept_o,
  input  logic              col_valid_i,
  input  logic [DATA_W-1:0] col_data0_i,
  input  logic [DATA_W-1:0] col_data1_i,
  input  logic [DATA_W-1:0] col_data2_i,
  input  logic [DATA_W-1:0] col_data3_i,
  input  logic [2:0]        col_idx_i,
  output logic              col_accept_o,
  output logic              outport_valid_o,
  output logic [DATA_W-1:0] outport_data0_o,
  output logic [DATA_W-1:0] outport_data1_o,
  output logic [DATA_W-1:0] outport_data2_o,
  output logic [DATA_W-1:0] outport_data3_o,
  output logic [2:0]        outport_idx_o,
  output logic              outport_pass_o,
  input  logic              outport_ready_i,
  output logic              idle_o,
  output logic              err_o
);

  localparam int BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [BEAT_W-1:0] c_last_beat = BEAT_W'(BURST_LEN - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ROW  = 2'd1,
    ST_COL  = 2'd2
  } state_t;

  state_t              r_state;
  logic [BEAT_W-1:0]   r_beat;
  logic                r_last;     // pass of the most recent grant, 1 = column
  logic                r_err;

  logic                w_sel_row;
  logic                w_sel_col;
  logic                w_fwd_valid;
  logic                w_fire;
  logic                w_lock;
  logic [2:0]          w_req_idx;
  logic [2:0]          w_beat_idx;
  logic [DATA_W-1:0]   w_data0;
  logic [DATA_W-1:0]   w_data1;
  logic [DATA_W-1:0]   w_data2;
  logic [DATA_W-1:0]   w_data3;

  // The beat counter is presented on a 3-bit index; shorter counters are
  // zero-extended, a 16-beat counter shows its low three bits.
  if (BEAT_W >= 3) begin : g_idx_trunc
    assign w_beat_idx = r_beat[2:0];
  end else begin : g_idx_ext
    assign w_beat_idx = {{(3-BEAT_W){1'b0}}, r_beat};
  end

  // Selection: in IDLE the winner is decided combinationally so the first
  // beat goes out with zero latency; once locked only the owner is selected,
  // even while it has dropped valid.
  always_comb begin
    w_sel_row = 1'b0;
    w_sel_col = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (row_valid_i && col_valid_i) begin
          if (PRIO_COL != 0) begin
            w_sel_col = 1'b1;
          end else if (r_last) begin
            w_sel_row = 1'b1;
          end else begin
            w_sel_col = 1'b1;
          end
        end else begin
          w_sel_row = row_valid_i;
          w_sel_col = col_valid_i;
        end
      end
      ST_ROW:  w_sel_row = 1'b1;
      ST_COL:  w_sel_col = 1'b1;
      default: begin
        w_sel_row = 1'b0;
        w_sel_col = 1'b0;
      end
    endcase
  end

  always_comb begin
    w_data0 = '0;
    w_data1 = '0;
    w_data2 = '0;
    w_data3 = '0;
    if (w_sel_col) begin
      w_data0 = col_data0_i;
      w_data1 = col_data1_i;
      w_data2 = col_data2_i;
      w_data3 = col_data3_i;
    end else if (w_sel_row) begin
      w_data0 = row_data0_i;
      w_data1 = row_data1_i;
      w_data2 = row_data2_i;
      w_data3 = row_data3_i;
    end
  end

  assign w_fwd_valid = (w_sel_row & row_valid_i) | (w_sel_col & col_valid_i);
  assign w_fire      = w_fwd_valid & outport_ready_i & ~img_start_i;
  assign w_lock      = (r_state == ST_IDLE) & (w_sel_row | w_sel_col);
  assign w_req_idx   = w_sel_col ? col_idx_i : row_idx_i;

  always_ff @(posedge clk_i) begin
    if (rst_i || img_start_i) begin
      r_state <= ST_IDLE;
      r_beat  <= '0;
      r_last  <= 1'b1;
      r_err   <= 1'b0;
    end else begin
      if (w_fwd_valid && (w_req_idx != w_beat_idx)) begin
        r_err <= 1'b1;
      end
      if (w_lock) begin
        r_last <= w_sel_col;
      end
      // Completing the burst returns to IDLE so the next grant can be issued
      // combinationally on the very next cycle without a bubble.
      if (w_fire && (r_beat == c_last_beat)) begin
        r_beat  <= '0;
        r_state <= ST_IDLE;
      end else begin
        if (w_fire) begin
          r_beat <= r_beat + BEAT_W'(1);
        end
        if (w_lock) begin
          r_state <= w_sel_col ? ST_COL : ST_ROW;
        end
      end
    end
  end

  assign row_accept_o    = w_sel_row & w_fire;
  assign col_accept_o    = w_sel_col & w_fire;
  assign outport_valid_o = w_fwd_valid;
  assign outport_data0_o = w_data0;
  assign outport_data1_o = w_data1;
  assign outport_data2_o = w_data2;
  assign outport_data3_o = w_data3;
  assign outport_idx_o   = w_beat_idx;
  assign outport_pass_o  = w_sel_col;
  assign idle_o          = (r_state == ST_IDLE) & ~row_valid_i & ~col_valid_i;
  assign err_o           = r_err;

endmodule
`default_nettype wire

// File: tb/tb_jpeg_idct_pass_arb.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_jpeg_idct_pass_arb                                         |
// | Purpose  : Self-checking bench for jpeg_idct_pass_arb. Two instances     |
// |            (round-robin and column-priority) share the random stimulus;  |
// |            each is compared every cycle against a burst-level model.     |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_jpeg_idct_pass_arb;

  localparam int DATA_W = 32;
  localparam int BL     = 8;
  localparam int NCYC   = 2400;

  logic clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic              rst_i;
  logic              img_start_i;
  logic              row_valid_i;
  logic              col_valid_i;
  logic              ready;
  logic [DATA_W-1:0] rd [4];
  logic [DATA_W-1:0] cd [4];
  logic [2:0]        row_idx [2];
  logic [2:0]        col_idx [2];

  logic              racc  [2];
  logic              cacc  [2];
  logic              ov    [2];
  logic              opass [2];
  logic              oidle [2];
  logic              oerr  [2];
  logic [2:0]        oidx  [2];
  logic [DATA_W-1:0] od    [2][4];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    jpeg_idct_pass_arb #(
      .DATA_W   (DATA_W),
      .BURST_LEN(BL),
      .PRIO_COL (g)
    ) u_dut (
      .clk_i          (clk_i),
      .rst_i          (rst_i),
      .img_start_i    (img_start_i),
      .row_valid_i    (row_valid_i),
      .row_data0_i    (rd[0]),
      .row_data1_i    (rd[1]),
      .row_data2_i    (rd[2]),
      .row_data3_i    (rd[3]),
      .row_idx_i      (row_idx[g]),
      .row_accept_o   (racc[g]),
      .col_valid_i    (col_valid_i),
      .col_data0_i    (cd[0]),
      .col_data1_i    (cd[1]),
      .col_data2_i    (cd[2]),
      .col_data3_i    (cd[3]),
      .col_idx_i      (col_idx[g]),
      .col_accept_o   (cacc[g]),
      .outport_valid_o(ov[g]),
      .outport_data0_o(od[g][0]),
      .outport_data1_o(od[g][1]),
      .outport_data2_o(od[g][2]),
      .outport_data3_o(od[g][3]),
      .outport_idx_o  (oidx[g]),
      .outport_pass_o (opass[g]),
      .outport_ready_i(ready),
      .idle_o         (oidle[g]),
      .err_o          (oerr[g])
    );
  end

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: owner 0 = nobody, 1 = row pass, 2 = column pass.
  // beats counts beats delivered in the current burst.
  int owner [2];
  int beats [2];
  int last  [2];   // owner of the latest grant
  int merr  [2];
  int rcnt  [2];   // requester-side beat counters, used to drive idx
  int ccnt  [2];

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      owner[i] = 0;
      beats[i] = 0;
      last[i]  = 2;
      merr[i]  = 0;
      rcnt[i]  = 0;
      ccnt[i]  = 0;
    end
  endtask

  // Compare this cycle's outputs and advance the model across the next edge.
  task automatic check_and_step();
    for (int i = 0; i < 2; i++) begin
      int   sel;
      int   req_idx;
      logic vld;
      logic acc;
      logic [DATA_W-1:0] ed [4];
      if (owner[i] != 0) begin
        sel = owner[i];
      end else if (row_valid_i && col_valid_i) begin
        sel = (i == 1) ? 2 : ((last[i] == 1) ? 2 : 1);
      end else if (row_valid_i) begin
        sel = 1;
      end else if (col_valid_i) begin
        sel = 2;
      end else begin
        sel = 0;
      end
      vld = (sel == 1) ? row_valid_i : ((sel == 2) ? col_valid_i : 1'b0);
      acc = vld && ready && !img_start_i;
      for (int l = 0; l < 4; l++) begin
        ed[l] = (sel == 1) ? rd[l] : ((sel == 2) ? cd[l] : '0);
      end
      chk($sformatf("p%0d_valid", i), 64'(ov[i]), 64'(vld));
      chk($sformatf("p%0d_pass", i), 64'(opass[i]), 64'(sel == 2));
      chk($sformatf("p%0d_idx", i), 64'(oidx[i]), 64'(beats[i]));
      chk($sformatf("p%0d_row_acc", i), 64'(racc[i]), 64'(acc && sel == 1));
      chk($sformatf("p%0d_col_acc", i), 64'(cacc[i]), 64'(acc && sel == 2));
      chk($sformatf("p%0d_idle", i), 64'(oidle[i]),
          64'(owner[i] == 0 && !row_valid_i && !col_valid_i));
      chk($sformatf("p%0d_err", i), 64'(oerr[i]), 64'(merr[i]));
      for (int l = 0; l < 4; l++) begin
        chk($sformatf("p%0d_data%0d", i, l), 64'(od[i][l]), 64'(ed[l]));
      end

      if (img_start_i) begin
        owner[i] = 0;
        beats[i] = 0;
        last[i]  = 2;
        merr[i]  = 0;
        rcnt[i]  = 0;
        ccnt[i]  = 0;
      end else begin
        req_idx = (sel == 2) ? int'(col_idx[i]) : int'(row_idx[i]);
        if (vld && req_idx != beats[i]) merr[i] = 1;
        if (owner[i] == 0 && sel != 0) last[i] = sel;
        if (acc) begin
          if (sel == 1) rcnt[i] = (rcnt[i] + 1) % BL;
          else          ccnt[i] = (ccnt[i] + 1) % BL;
          beats[i] = beats[i] + 1;
        end
        if (beats[i] == BL) begin
          beats[i] = 0;
          owner[i] = 0;
        end else begin
          owner[i] = sel;
        end
      end
    end
  endtask

  initial begin
    logic [2:0] mask;
    int         ph;
    rst_i       = 1'b1;
    img_start_i = 1'b0;
    row_valid_i = 1'b0;
    col_valid_i = 1'b0;
    ready       = 1'b0;
    for (int l = 0; l < 4; l++) begin
      rd[l] = '0;
      cd[l] = '0;
    end
    for (int i = 0; i < 2; i++) begin
      row_idx[i] = '0;
      col_idx[i] = '0;
    end
    model_reset();
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    // Reset state with no requests: everything 0 except idle.
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("rst%0d_valid", i), 64'(ov[i]), 64'd0);
      chk($sformatf("rst%0d_idle", i), 64'(oidle[i]), 64'd1);
      chk($sformatf("rst%0d_err", i), 64'(oerr[i]), 64'd0);
      chk($sformatf("rst%0d_pass", i), 64'(opass[i]), 64'd0);
      chk($sformatf("rst%0d_data0", i), 64'(od[i][0]), 64'd0);
    end
    @(posedge clk_i);
    #1 rst_i = 1'b0;

    for (int cyc = 0; cyc < NCYC; cyc++) begin
      // Phases: row only, both continuously valid, random traffic,
      // random traffic with index corruption and image flushes.
      ph = (cyc < 200) ? 0 : (cyc < 700) ? 1 : (cyc < 1500) ? 2 : 3;
      row_valid_i = (ph == 1) ? 1'b1
                  : (ph == 0) ? ($urandom_range(0, 7) != 0)
                  : ($urandom_range(0, 4) != 0);
      col_valid_i = (ph == 0) ? 1'b0
                  : (ph == 1) ? ((cyc < 450) ? 1'b1 : ($urandom_range(0, 9) != 0))
                  : ($urandom_range(0, 4) != 0);
      ready       = (ph <= 1) ? 1'b1 : ($urandom_range(0, 9) < 7);
      img_start_i = (ph >= 2) ? ($urandom_range(0, 69) == 0) : 1'b0;
      mask        = (ph == 3 && $urandom_range(0, 39) == 0)
                  ? 3'($urandom_range(1, 7)) : 3'd0;
      for (int l = 0; l < 4; l++) begin
        rd[l] = DATA_W'($urandom);
        cd[l] = DATA_W'($urandom);
      end
      for (int i = 0; i < 2; i++) begin
        row_idx[i] = 3'(rcnt[i]) ^ mask;
        col_idx[i] = 3'(ccnt[i]) ^ mask;
      end
      @(negedge clk_i);
      check_and_step();
      @(posedge clk_i);
      #1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
